cordic_sincos: RTL
==================

# cordic_sincos

Parametrised iterative CORDIC sine/cosine unit, the fixed-point successor to the single-width sincos block. It takes a binary-scaled angle covering the full circle and a start pulse. It returns signed fixed-point sine and cosine after a fixed, parameter-derived latency with a busy/done handshake. It sits beside the FP datapath as the trig engine; any float conversion is done by the caller.

## Interface
- WIDTH, 16, angle and result width in bits; legal range 8..30
- ITER, 16, number of CORDIC micro-rotations; legal range 4..WIDTH
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- angle  in  WIDTH  unsigned binary angle; value a = 2π·a/2^WIDTH rad
- busy  out  1  high in RUN and MAP
- done  out  1  one-cycle pulse in DONE; results valid from this cycle
- sine_result  out  WIDTH  signed, 1.0 = 2^(WIDTH-2)
- cosine_result  out  WIDTH  signed, same scaling

## Operation
- Quadrant: q = angle[WIDTH-1:WIDTH-2]; residual z0 = angle with top two bits cleared, so z0 ∈ [0°, 90°).
- Internal x, y, z registers are WIDTH+2 bits signed (2 guard bits).
- Load values: x = round(K·2^WIDTH), y = 0, z = z0 (zero-extended), i = 0. K = ∏ 1/√(1+2^-2i) over ITER terms.
- Iteration i: d = (z ≥ 0) ? +1 : −1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
  - Shifts are arithmetic. atan_i is atan(2^-i) in binary-angle units, rounded to WIDTH+2 bits.
- Output mapping in MAP, with s = y>>>2 and c = x>>>2 (round-half-up):
  - q=0: (s, c)
  - q=1: (c, −s)
  - q=2: (−s, −c)
  - q=3: (−c, s)
- Outputs are clamped to [−2^(WIDTH-2), +2^(WIDTH-2)].
- sine_result and cosine_result hold their value until the next MAP. They are not cleared by start.
- Accuracy: |error| ≤ 4 LSB for WIDTH = ITER = 16.

## Timing
- FSM states: IDLE, RUN, MAP, DONE.
- IDLE: start=1 → load registers, latch q, go to RUN.
- RUN: one iteration per cycle. After iteration ITER−1 → MAP.
- MAP: register mapped outputs → DONE.
- DONE: done=1. start=1 → load and go to RUN (back-to-back). Otherwise → IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge ITER+1. Throughput is one result per ITER+2 cycles.
- start during RUN or MAP is ignored. angle is sampled only at the accepting edge.
- Reset (any time, including mid-iteration):
  - state = IDLE
  - busy = 0, done = 0
  - sine_result = 0, cosine_result = 0
  - x, y, z, i, q = 0
- No partial result is ever presented after reset.

## Structure
- Package cordic_pkg holds:
  - the state enum
  - function atan_lut(i, w) returning atan(2^-i) scaled to w bits
  - function cordic_gain(iter, w) returning round(K·2^w)
  - constants MIN_WIDTH = 8, MAX_WIDTH = 30
- One sub-module, cordic_quad_map: combinational quadrant remap, rescale and clamp (inputs q, x, y; outputs sin, cos).
- Iteration datapath and FSM live in cordic_sincos. The elaboration-time assertion on ITER ≤ WIDTH also lives there.

## Test plan
All cases use WIDTH = ITER = 16. Results within ±4 LSB of the stated values; done arrives exactly 17 edges after the start edge.
- Reset, then angle 0x0000 with start → sin 0, cos 16384.
- 0x2000 (45°) → 11585, 11585.
- 0x4000 (90°) → 16384, 0.
- 0xC000 (270°) → −16384, 0.
- 0xE000 (315°) → −11585, 11585.
- Start in DONE with 0x8000 → busy re-asserts with no IDLE gap; result −0, −16384.
- Start pulses at cycles 3 and 10 after an accepted start → ignored; result matches the first angle; exactly one done.
- n_rst low at cycle 8 of RUN → outputs and busy = 0 immediately; no done; fresh start gives a correct result.

Source files
------------

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sine/cosine unit:
//   - state_t      : controller states
//   - atan_lut     : atan(2^-i) in binary-angle units (full circle = 2^w)
//   - cordic_gain  : round(K * 2^w), K = prod 1/sqrt(1 + 2^-2i)
//   - MIN_WIDTH / MAX_WIDTH : legal WIDTH range
// Both functions use only 64-bit integer arithmetic, so they evaluate as
// elaboration-time constants without any real-number support.
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 30;

  // Fractional bits of the fixed-point scratch format used by the functions.
  localparam int FRAC = 56;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MAP,
    S_DONE
  } state_t;

  // atan(1/n) as a FRAC-bit fixed-point number, by the Taylor series.
  // Only called with n >= 2, where the series converges quickly.
  function automatic longint atan_inv(input longint n);
    longint p;
    longint n2;
    longint sum;
    sum = 0;
    n2  = n * n;
    p   = (longint'(1) <<< FRAC) / n;
    for (int k = 0; k < 64 && p != 0; k++) begin
      if (k % 2 == 0) sum = sum + p / (2 * k + 1);
      else            sum = sum - p / (2 * k + 1);
      p = p / n2;
    end
    return sum;
  endfunction

  // atan(2^-i) in binary-angle units where 2^w is a full turn.
  // Scaled against pi/4 (Machin's formula), which is exactly 2^(w-3).
  function automatic longint atan_lut(input int i, input int w);
    longint pi4;
    longint den;
    longint res;
    if (i == 0) begin
      res = longint'(1) <<< (w - 3);
    end else begin
      pi4 = 4 * atan_inv(5) - atan_inv(239);
      den = pi4 >>> (w - 3);
      res = (atan_inv(longint'(1) <<< i) + den / 2) / den;
    end
    return res;
  endfunction

  // round(K * 2^w) for an iter-stage CORDIC.
  function automatic longint cordic_gain(input int iter, input int w);
    longint k2;
    longint u;
    longint r;
    longint trial;
    // K^2 = prod 1/(1 + 4^-i); each factor is 1 - 1/(4^i + 1).
    k2 = longint'(1) <<< FRAC;
    for (int i = 0; i < iter; i++) begin
      k2 = k2 - k2 / ((longint'(1) <<< (2 * i)) + 1);
    end
    // u = K^2 * 2^(2w+2), so floor(sqrt(u)) = floor(2 * K * 2^w).
    if (2 * w + 2 >= FRAC) u = k2 <<< (2 * w + 2 - FRAC);
    else                   u = k2 >>> (FRAC - 2 * w - 2);
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      trial = r | (longint'(1) <<< b);
      if (trial * trial <= u) r = trial;
    end
    return (r + 1) >>> 1;
  endfunction

endpackage

// File: rtl/cordic_quad_map.sv
// -----------------------------------------------------------------------------
// cordic_quad_map
// Combinational back end of the CORDIC unit: drops the two guard bits with
// round-half-up, rotates the first-quadrant result into quadrant q and clamps
// to +/-1.0 (1.0 = 2^(WIDTH-2)).
//   q    in  2        quadrant of the original angle
//   x    in  WIDTH+2  final CORDIC x (cosine of residual, 1.0 = 2^WIDTH)
//   y    in  WIDTH+2  final CORDIC y (sine of residual)
//   sin  out WIDTH    mapped, clamped sine
//   cos  out WIDTH    mapped, clamped cosine
// -----------------------------------------------------------------------------
module cordic_quad_map #(
  parameter int WIDTH = 16
) (
  input  logic        [1:0]       q,
  input  logic signed [WIDTH+1:0] x,
  input  logic signed [WIDTH+1:0] y,
  output logic signed [WIDTH-1:0] sin,
  output logic signed [WIDTH-1:0] cos
);

  localparam int ZW  = WIDTH + 2;
  localparam int LIM = 1 << (WIDTH - 2);

  logic signed [ZW-1:0] s;
  logic signed [ZW-1:0] c;
  logic signed [ZW-1:0] sin_w;
  logic signed [ZW-1:0] cos_w;

  // Add half an output LSB before discarding the two guard bits.
  assign s = (y + ZW'(2)) >>> 2;
  assign c = (x + ZW'(2)) >>> 2;

  always_comb begin
    sin_w = s;
    cos_w = c;
    case (q)
      2'd0:    begin sin_w = s;  cos_w = c;  end
      2'd1:    begin sin_w = c;  cos_w = -s; end
      2'd2:    begin sin_w = -s; cos_w = -c; end
      default: begin sin_w = -c; cos_w = s;  end
    endcase
  end

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [ZW-1:0] v);
    if (v > ZW'(LIM))       clamp = WIDTH'(LIM);
    else if (v < ZW'(-LIM)) clamp = WIDTH'(-LIM);
    else                    clamp = WIDTH'(v);
  endfunction

  assign sin = clamp(sin_w);
  assign cos = clamp(cos_w);

endmodule

// File: rtl/cordic_sincos.sv
// -----------------------------------------------------------------------------
// cordic_sincos
// Iterative rotation-mode CORDIC producing sine and cosine of a binary angle.
// One micro-rotation per cycle; a result every ITER+2 cycles.
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   start          in   request, accepted only in IDLE or DONE
//   angle          in   WIDTH  unsigned binary angle, 2^WIDTH = full turn
//   busy           out  high while iterating (RUN) and mapping (MAP)
//   done           out  one-cycle pulse; results valid from this cycle
//   sine_result    out  WIDTH  signed, 1.0 = 2^(WIDTH-2), held until next MAP
//   cosine_result  out  WIDTH  signed, same scaling
// -----------------------------------------------------------------------------
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic        [WIDTH-1:0] angle,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] sine_result,
  output logic signed [WIDTH-1:0] cosine_result
);

  localparam int     ZW   = WIDTH + 2;
  localparam int     IW   = $clog2(ITER);
  localparam longint GAIN = cordic_gain(ITER, WIDTH);

  if (ITER > WIDTH || ITER < 4 || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_param_check
    $error("cordic_sincos: need 4 <= ITER <= WIDTH and MIN_WIDTH <= WIDTH <= MAX_WIDTH");
  end

  // NOTE: the angle table is a set of elaboration-time constants, not a RAM,
  // so it has no storage to reset.
  logic signed [ZW-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam longint ATAN_G = atan_lut(g, WIDTH);
    assign atan_tab[g] = ZW'(ATAN_G);
  end

  state_t               state;
  state_t               state_next;
  logic signed [ZW-1:0] x;
  logic signed [ZW-1:0] y;
  logic signed [ZW-1:0] z;
  logic        [IW-1:0] i;
  logic        [1:0]    q;
  logic signed [ZW-1:0] x_shift;
  logic signed [ZW-1:0] y_shift;
  logic signed [ZW-1:0] atan_i;
  logic                 load;
  logic                 last_iter;
  logic signed [WIDTH-1:0] map_sin;
  logic signed [WIDTH-1:0] map_cos;

  assign load      = start && (state == S_IDLE || state == S_DONE);
  assign last_iter = (i == IW'(ITER - 1));
  assign busy      = (state == S_RUN) || (state == S_MAP);
  assign done      = (state == S_DONE);

  // ---------------------------------------------------------------- control
  // NOTE: clocked blocks use non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default first, so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_iter) state_next = S_MAP;
      S_MAP:   state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  // x and y are signed, so >>> replicates the sign bit.
  assign x_shift = x >>> i;
  assign y_shift = y >>> i;
  assign atan_i  = atan_tab[i];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      q <= '0;
    end else if (load) begin
      // Pre-scaling x by K cancels the CORDIC gain, so |(x, y)| ends at 2^WIDTH.
      x <= ZW'(GAIN);
      y <= '0;
      z <= ZW'(angle[WIDTH-3:0]);
      i <= '0;
      q <= angle[WIDTH-1 -: 2];
    end else if (state == S_RUN) begin
      // Rotate toward z = 0: positive residual turns counter-clockwise.
      if (!z[ZW-1]) begin
        x <= x - y_shift;
        y <= y + x_shift;
        z <= z - atan_i;
      end else begin
        x <= x + y_shift;
        y <= y - x_shift;
        z <= z + atan_i;
      end
      i <= i + IW'(1);
    end
  end

  cordic_quad_map #(
    .WIDTH (WIDTH)
  ) u_quad_map (
    .q   (q),
    .x   (x),
    .y   (y),
    .sin (map_sin),
    .cos (map_cos)
  );

  // Results change only in MAP; a new start leaves the previous pair visible.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sine_result   <= '0;
      cosine_result <= '0;
    end else if (state == S_MAP) begin
      sine_result   <= map_sin;
      cosine_result <= map_cos;
    end
  end

endmodule
